// File: rtl/shift_issue_stage.sv
// shift_issue_stage
// Issue stage in front of an external combinational 16-bit shifter. Requests
// are held in a 2-entry FIFO. The head entry drives the shifter. The shifter
// result is captured into a valid/ready output register. Capacity is 3 requests
// in flight: 2 in the queue and 1 in the output register.
// Optional feature: define SHIFT_ISSUE_STAT_EN to add op_cnt. This is a
// saturating count of completed output handshakes.
module shift_issue_stage #(
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_num,
  input  logic [4:0]  in_amt,
  input  logic        in_dir,
  input  logic        in_logical,
  output logic [15:0] sh_num,
  output logic [5:0]  sh_count,
  output logic        sh_op_type,
  input  logic [15:0] sh_o,
`ifdef SHIFT_ISSUE_STAT_EN
  output logic [15:0] op_cnt,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_zero
);

  typedef struct packed {
    logic [15:0] num;
    logic [5:0]  count;   // two's complement, negative means shift right
    logic        logical;
  } entry_t;

  entry_t      mem_q [QDEPTH];
  entry_t      mem_d [QDEPTH];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  occ_q, occ_d;
  logic        alive_q, alive_d;     // rst_n was high on the previous edge
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_zero_q, out_zero_d;
`ifdef SHIFT_ISSUE_STAT_EN
  logic [15:0] op_cnt_q, op_cnt_d;
`endif

  logic        push, pop;
  entry_t      in_entry;
  entry_t      head;

  // Handshake decisions, count encoding, head selection and next state.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    in_ready = alive_q && (occ_q < 2'(QDEPTH));
    push     = in_valid && in_ready;
    pop      = (occ_q != 2'd0) && (!out_valid_q || out_ready);

    in_entry.num     = in_num;
    in_entry.logical = in_logical;
    if (!in_dir)             in_entry.count = {1'b0, in_amt};
    else if (in_amt == 5'd0) in_entry.count = 6'd0;
    else                     in_entry.count = 6'd0 - {1'b0, in_amt};

    // An empty queue presents a neutral request to the shifter.
    head = '{num: 16'h0000, count: 6'd0, logical: 1'b1};
    if (occ_q != 2'd0) head = mem_q[rd_ptr_q];

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_entry;

    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    occ_d    = occ_q + 2'(push) - 2'(pop);
    alive_d  = 1'b1;

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_zero_d  = out_zero_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = sh_o;
      out_zero_d  = (sh_o == 16'h0000);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

`ifdef SHIFT_ISSUE_STAT_EN
    op_cnt_d = op_cnt_q;
    if (out_valid_q && out_ready && (op_cnt_q != 16'hFFFF)) op_cnt_d = op_cnt_q + 16'd1;
`endif
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
      alive_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_zero_q  <= 1'b1;
`ifdef SHIFT_ISSUE_STAT_EN
      op_cnt_q    <= 16'd0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      alive_q     <= alive_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
`ifdef SHIFT_ISSUE_STAT_EN
      op_cnt_q    <= op_cnt_d;
`endif
    end
  end

  // Queue payload storage.
  always_ff @(posedge clk) begin
    // NOTE: payload is not reset; occupancy is cleared, so stale entries are never read.
    mem_q <= mem_d;
  end

  assign sh_num     = head.num;
  assign sh_count   = head.count;
  assign sh_op_type = head.logical;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_zero   = out_zero_q;
`ifdef SHIFT_ISSUE_STAT_EN
  assign op_cnt     = op_cnt_q;
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage
// Self-checking bench for shift_issue_stage. The bench supplies the downstream
// shifter itself. A transaction-level reference keeps in-flight requests in a
// queue. Expected results are computed directly from the request fields.
// Define SHIFT_ISSUE_STAT_EN to include the op_cnt checks.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_num;
  logic [4:0]  in_amt;
  logic        in_dir;
  logic        in_logical;
  logic [15:0] sh_num;
  logic [5:0]  sh_count;
  logic        sh_op_type;
  logic [15:0] sh_o;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
`ifdef SHIFT_ISSUE_STAT_EN
  logic [15:0] op_cnt;
`endif

  always #5 clk = ~clk;

  shift_issue_stage #(.QDEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_num     (in_num),
    .in_amt     (in_amt),
    .in_dir     (in_dir),
    .in_logical (in_logical),
    .sh_num     (sh_num),
    .sh_count   (sh_count),
    .sh_op_type (sh_op_type),
    .sh_o       (sh_o),
`ifdef SHIFT_ISSUE_STAT_EN
    .op_cnt     (op_cnt),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero)
  );

  // Downstream combinational shifter: signed count, right shift when negative.
  always_comb begin
    logic [63:0] ext;
    int          n;
    ext  = {48'h0, sh_num};
    if (!sh_op_type) ext = {{48{sh_num[15]}}, sh_num};
    n    = 0;
    sh_o = 16'h0000;
    if (!sh_count[5]) begin
      sh_o = 16'(ext << sh_count);
    end else begin
      n    = 64 - int'(sh_count);
      sh_o = 16'(ext >> n);
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] num;
    logic [5:0]  cnt;
    logic        lg;
    logic [15:0] res;
  } req_t;

  req_t        mq[$];
  logic        m_alive = 1'b0;
  logic        m_ov    = 1'b0;
  logic [15:0] m_od    = 16'h0000;
  logic        m_oz    = 1'b1;
  int          m_cnt   = 0;
  logic        last_acc;

  function automatic logic [5:0] enc(input logic [4:0] amt, input logic dir);
    if (!dir) return {1'b0, amt};
    return 6'((64 - int'(amt)) % 64);
  endfunction

  function automatic logic [15:0] ref_shift(input logic [15:0] num, input logic [4:0] amt,
                                            input logic dir, input logic lg);
    logic signed [15:0] s;
    s = num;
    if (!dir) return (amt >= 5'd16) ? 16'h0000 : 16'(num << amt);
    if (lg)   return num >> amt;
    return 16'(s >>> amt);
  endfunction

  task automatic compare_all();
    check("in_ready",  in_ready,  m_alive && (mq.size() < 2));
    check("out_valid", out_valid, m_ov);
    check("out_data",  out_data,  m_od);
    check("out_zero",  out_zero,  m_oz);
    if (mq.size() != 0) begin
      check("sh_num",     sh_num,     mq[0].num);
      check("sh_count",   sh_count,   mq[0].cnt);
      check("sh_op_type", sh_op_type, mq[0].lg);
    end else begin
      check("sh_num_empty",     sh_num,     16'h0000);
      check("sh_count_empty",   sh_count,   6'd0);
      check("sh_op_type_empty", sh_op_type, 1'b1);
    end
`ifdef SHIFT_ISSUE_STAT_EN
    check("op_cnt", op_cnt, m_cnt);
`endif
  endtask

  // One clock cycle: drive at the falling edge, advance the model, check at the next falling edge.
  task automatic cycle(input logic v, input logic [15:0] num, input logic [4:0] amt,
                       input logic dir, input logic lg, input logic ordy, input logic rn);
    req_t e;
    logic m_rdy, m_push, m_pop;
    in_valid   = v;
    in_num     = num;
    in_amt     = amt;
    in_dir     = dir;
    in_logical = lg;
    out_ready  = ordy;
    rst_n      = rn;
    last_acc   = v && in_ready && rn;
    m_rdy      = m_alive && (mq.size() < 2);
    if (!rn) begin
      mq.delete();
      m_ov = 1'b0; m_od = 16'h0000; m_oz = 1'b1; m_alive = 1'b0; m_cnt = 0;
    end else begin
      m_pop  = (mq.size() != 0) && (!m_ov || ordy);
      m_push = v && m_rdy;
      if (m_ov && ordy && m_cnt < 65535) m_cnt++;
      if (m_pop) begin
        e    = mq.pop_front();
        m_ov = 1'b1;
        m_od = e.res;
        m_oz = (e.res == 16'h0000);
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      if (m_push) begin
        e.num = num;
        e.cnt = enc(amt, dir);
        e.lg  = lg;
        e.res = ref_shift(num, amt, dir, lg);
        mq.push_back(e);
      end
      m_alive = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, ordy, 1'b1);
  endtask

  initial begin
    logic [15:0] reqs [4];
    int          idx;
    rst_n = 1'b0; in_valid = 1'b0; in_num = '0; in_amt = '0; in_dir = 1'b0;
    in_logical = 1'b0; out_ready = 1'b0; last_acc = 1'b0;
    @(negedge clk);

    // Reset state.
    cycle(1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_in_ready",  in_ready,  1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  16'h0000);
    check("rst_out_zero",  out_zero,  1'b1);
    idle(1'b1);
    check("post_rst_in_ready", in_ready, 1'b1);

    // Left shift, one-cycle latency.
    cycle(1'b1, 16'h0001, 5'd4, 1'b0, 1'b1, 1'b1, 1'b1);
    check("l4_sh_count", sh_count, 6'd4);
    idle(1'b1);
    check("l4_out_valid", out_valid, 1'b1);
    check("l4_out_data",  out_data,  16'h0010);
    check("l4_out_zero",  out_zero,  1'b0);

    // Arithmetic and logical right shift by 3.
    cycle(1'b1, 16'h8000, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    check("r3a_sh_count", sh_count, 6'b111101);
    cycle(1'b1, 16'h8000, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    check("r3a_out_data", out_data, 16'hF000);
    check("r3l_sh_count", sh_count, 6'b111101);
    idle(1'b1);
    check("r3l_out_data", out_data, 16'h1000);

    // Right by zero, left by 16.
    cycle(1'b1, 16'h1234, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("r0_sh_count", sh_count, 6'd0);
    cycle(1'b1, 16'h00FF, 5'd16, 1'b0, 1'b0, 1'b1, 1'b1);
    check("r0_out_data", out_data, 16'h1234);
    idle(1'b1);
    check("l16_out_data", out_data, 16'h0000);
    check("l16_out_zero", out_zero, 1'b1);
    idle(1'b1);

    // Backpressure: four requests offered with out_ready low, only three fit.
    for (int i = 0; i < 4; i++) reqs[i] = 16'h1111 * 16'(i + 1);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) cycle(1'b1, reqs[idx], 5'(idx), 1'b0, 1'b1, 1'b0, 1'b1);
      else         idle(1'b0);
      if (last_acc) idx++;
    end
    check("bp_accepted", idx, 3);
    check("bp_in_ready", in_ready, 1'b0);
    for (int c = 0; c < 4 && idx < 4; c++) begin
      cycle(1'b1, reqs[3], 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
      if (last_acc) idx++;
    end
    check("bp_fourth_accepted", idx, 4);
    for (int c = 0; c < 5; c++) idle(1'b1);

    // Reset with two queued and a result pending.
    cycle(1'b1, 16'h0F0F, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 16'hF0F0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 16'h00AA, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    check("mid_out_valid", out_valid, 1'b1);
    cycle(1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready",  in_ready,  1'b0);
    idle(1'b1);
    check("mid_rst_in_ready_next", in_ready,  1'b1);
    check("mid_rst_sh_op_type",    sh_op_type, 1'b1);
    idle(1'b1);
    check("mid_rst_no_stale", out_valid, 1'b0);

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 600; c++) begin
      cycle(1'($urandom % 4 != 0), 16'($urandom), 5'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom % 3 != 0), 1'($urandom % 64 != 0));
    end
    for (int c = 0; c < 4; c++) idle(1'b1);

`ifdef SHIFT_ISSUE_STAT_EN
    // Completion counter: five handshakes from reset, then saturation.
    cycle(1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(i + 1), 5'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("op_cnt_five", op_cnt, 16'd5);
    force dut.op_cnt_q = 16'hFFFE;
    #1;
    release dut.op_cnt_q;
    m_cnt = 65534;
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h0101, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("op_cnt_sat", op_cnt, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
